// File: rtl/sync_fifo_parallel_gather.sv
// Narrow-to-wide gather FIFO: packs NUM_SPLITS narrow words (lane 0 first) into a show-ahead wide FIFO.
// Optional partial-word flush with per-entry lane mask when SYNC_FIFO_GATHER_FLUSH_EN is defined.
module sync_fifo_parallel_gather #(
   parameter int SPLIT_WIDTH          = 32,
   parameter int NUM_SPLITS           = 8,
   parameter int NUM_SPLITS_BIT_WIDTH = 3,
   parameter int FIFO_DEPTH           = 8,
   parameter int APPARENT_DEPTH       = 6,
   parameter int POINTER_SIZE         = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              valid,
   input  logic [SPLIT_WIDTH-1:0]            data,
   input  logic                              read,
`ifdef SYNC_FIFO_GATHER_FLUSH_EN
   input  logic                              flush,
`endif
   output logic                              fifoFull,
   output logic                              fifoEmpty,
   output logic                              overflow,
   output logic [NUM_SPLITS*SPLIT_WIDTH-1:0] out
`ifdef SYNC_FIFO_GATHER_FLUSH_EN
   ,
   output logic [NUM_SPLITS-1:0]             outMask
`endif
);

   localparam int WIDE  = NUM_SPLITS * SPLIT_WIDTH;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [NUM_SPLITS_BIT_WIDTH-1:0] LAST_LANE = NUM_SPLITS_BIT_WIDTH'(NUM_SPLITS - 1);

   logic [NUM_SPLITS_BIT_WIDTH-1:0] lane_q, lane_d;
   logic [WIDE-1:0]                 gather_q, gather_d;
   logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
   logic [POINTER_SIZE-1:0]         count_q, count_d;
   logic                            fifo_full_q, fifo_full_d;
   logic                            overflow_q, overflow_d;

   logic [WIDE-1:0] mem_q [FIFO_DEPTH];
   logic [WIDE-1:0] commit_word;
   logic            commit;
   logic            pop;
   logic            drop;
   logic            wr_en;

`ifdef SYNC_FIFO_GATHER_FLUSH_EN
   logic [NUM_SPLITS-1:0]         mask_mem_q [FIFO_DEPTH];
   logic [NUM_SPLITS-1:0]         commit_mask;
   logic [NUM_SPLITS_BIT_WIDTH:0] fill;
`endif

   always_comb begin
      commit_word = gather_q;
      if (valid) begin
         commit_word[lane_q*SPLIT_WIDTH +: SPLIT_WIDTH] = data;
      end
`ifdef SYNC_FIFO_GATHER_FLUSH_EN
      // A flush only commits if at least one lane holds data (including this cycle's word).
      commit = (valid && (lane_q == LAST_LANE)) || (flush && (valid || (lane_q != '0)));
      fill   = {1'b0, lane_q} + {{NUM_SPLITS_BIT_WIDTH{1'b0}}, valid};
      for (int k = 0; k < NUM_SPLITS; k++) begin
         commit_mask[k] = (k < int'(fill));
      end
`else
      commit = valid && (lane_q == LAST_LANE);
`endif

      lane_d   = lane_q;
      gather_d = gather_q;
      if (commit) begin
         lane_d   = '0;
         gather_d = '0;
      end else if (valid) begin
         lane_d   = lane_q + 1'b1;
         gather_d = commit_word;
      end

      pop   = read && (count_q != '0);
      // A simultaneous pop frees the head slot, so a commit at full occupancy still lands.
      drop  = commit && (count_q == POINTER_SIZE'(FIFO_DEPTH)) && !pop;
      wr_en = commit && !drop;

      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      overflow_d  = overflow_q | drop;
      fifo_full_d = (count_q >= POINTER_SIZE'(APPARENT_DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_q      <= '0;
         gather_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         fifo_full_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         lane_q      <= lane_d;
         gather_q    <= gather_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         fifo_full_q <= fifo_full_d;
         overflow_q  <= overflow_d;
      end
   end

   // Storage needs no reset: out is forced to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= commit_word;
`ifdef SYNC_FIFO_GATHER_FLUSH_EN
         mask_mem_q[wr_ptr_q] <= commit_mask;
`endif
      end
   end

   always_comb begin
      fifoEmpty = (count_q == '0);
      fifoFull  = fifo_full_q;
      overflow  = overflow_q;
      out       = fifoEmpty ? '0 : mem_q[rd_ptr_q];
`ifdef SYNC_FIFO_GATHER_FLUSH_EN
      outMask   = fifoEmpty ? '0 : mask_mem_q[rd_ptr_q];
`endif
   end

endmodule

// File: tb/tb_sync_fifo_parallel_gather.sv
// Directed self-checking bench for sync_fifo_parallel_gather; flush cases run when SYNC_FIFO_GATHER_FLUSH_EN is defined.
module tb_sync_fifo_parallel_gather;

   logic         clk;
   logic         rst;
   logic         valid;
   logic [31:0]  data;
   logic         read;
   logic         fifoFull;
   logic         fifoEmpty;
   logic         overflow;
   logic [255:0] out;
`ifdef SYNC_FIFO_GATHER_FLUSH_EN
   logic         flush;
   logic [7:0]   outMask;
`endif

   int checks = 0;
   int errors = 0;

   sync_fifo_parallel_gather dut (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .data      (data),
      .read      (read),
`ifdef SYNC_FIFO_GATHER_FLUSH_EN
      .flush     (flush),
`endif
      .fifoFull  (fifoFull),
      .fifoEmpty (fifoEmpty),
      .overflow  (overflow),
      .out       (out)
`ifdef SYNC_FIFO_GATHER_FLUSH_EN
      ,
      .outMask   (outMask)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] mk_word(input logic [31:0] base);
      logic [255:0] w;
      w = '0;
      for (int k = 0; k < 8; k++) w[k*32 +: 32] = base + 32'(k);
      return w;
   endfunction

   task automatic push_lanes(input logic [31:0] base, input int first, input int n);
      for (int k = 0; k < n; k++) begin
         valid = 1'b1;
         data  = base + 32'(first + k);
         cyc();
      end
      valid = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] base, input bit rd_last);
      for (int k = 0; k < 8; k++) begin
         valid = 1'b1;
         data  = base + 32'(k);
         read  = rd_last && (k == 7);
         cyc();
      end
      valid = 1'b0;
      read  = 1'b0;
   endtask

   task automatic pop();
      read = 1'b1;
      cyc();
      read = 1'b0;
   endtask

   logic [255:0] exp_w;

   initial begin
      rst   = 1'b1;
      valid = 1'b0;
      data  = '0;
      read  = 1'b0;
`ifdef SYNC_FIFO_GATHER_FLUSH_EN
      flush = 1'b0;
`endif
      #3;
      chk("rst_empty",    256'(fifoEmpty), 256'(1));
      chk("rst_full",     256'(fifoFull),  256'(0));
      chk("rst_overflow", 256'(overflow),  256'(0));
      chk("rst_out",      out,             '0);
`ifdef SYNC_FIFO_GATHER_FLUSH_EN
      chk("rst_mask",     256'(outMask),   256'(0));
`endif
      cyc();
      rst = 1'b0;
      cyc();

      // First word: latency of one edge after the last lane.
      push_lanes(32'h0, 0, 7);
      chk("empty_before_last_lane", 256'(fifoEmpty), 256'(1));
      push_lanes(32'h0, 7, 1);
      chk("empty_after_last_lane", 256'(fifoEmpty), 256'(0));
      chk("first_word", out, mk_word(32'h0));
      pop();
      chk("empty_after_pop", 256'(fifoEmpty), 256'(1));
      chk("out_zero_empty",  out,             '0);

      // Reads on an empty FIFO must not disturb the pointers.
      read = 1'b1;
      repeat (10) cyc();
      read = 1'b0;
      chk("empty_read_still_empty", 256'(fifoEmpty), 256'(1));
      push_word(32'h50, 1'b0);
      chk("word_after_empty_reads", out, mk_word(32'h50));
      pop();
      chk("empty_after_second_pop", 256'(fifoEmpty), 256'(1));

      // Fill to apparent depth, then to physical depth, then overflow.
      for (int i = 1; i <= 6; i++) push_word(32'(i) << 8, 1'b0);
      chk("full_lags_count", 256'(fifoFull), 256'(0));
      cyc();
      chk("full_at_6", 256'(fifoFull), 256'(1));
      push_word(32'h700, 1'b0);
      push_word(32'h800, 1'b0);
      chk("no_overflow_at_8", 256'(overflow), 256'(0));
      chk("full_at_8",        256'(fifoFull), 256'(1));
      push_word(32'h900, 1'b0);
      chk("overflow_on_9th", 256'(overflow), 256'(1));
      for (int i = 1; i <= 8; i++) begin
         chk($sformatf("drain_word_%0d", i), out, mk_word(32'(i) << 8));
         pop();
      end
      chk("empty_after_drain", 256'(fifoEmpty), 256'(1));
      cyc();
      chk("full_clear_after_drain", 256'(fifoFull), 256'(0));
      chk("overflow_sticky",        256'(overflow), 256'(1));

      // Commit and pop together at full occupancy.
      rst = 1'b1;
      #2;
      chk("overflow_cleared_by_rst", 256'(overflow),  256'(0));
      chk("empty_after_rst",         256'(fifoEmpty), 256'(1));
      cyc();
      rst = 1'b0;
      cyc();
      for (int i = 1; i <= 8; i++) push_word(32'(i) << 8, 1'b0);
      push_word(32'h900, 1'b1);
      chk("no_overflow_commit_pop", 256'(overflow), 256'(0));
      chk("full_commit_pop",        256'(fifoFull), 256'(1));
      for (int i = 2; i <= 9; i++) begin
         chk($sformatf("cp_word_%0d", i), out, mk_word(32'(i) << 8));
         pop();
      end
      chk("empty_after_cp_drain", 256'(fifoEmpty), 256'(1));

      // Reset mid-word discards the partial gather.
      push_lanes(32'hE0, 0, 3);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
      push_word(32'h70, 1'b0);
      chk("post_rst_word", out, mk_word(32'h70));
      pop();
      chk("single_word_after_rst", 256'(fifoEmpty), 256'(1));

`ifdef SYNC_FIFO_GATHER_FLUSH_EN
      push_lanes(32'h0, 10, 3);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      exp_w = '0;
      exp_w[31:0]  = 32'hA;
      exp_w[63:32] = 32'hB;
      exp_w[95:64] = 32'hC;
      chk("flush3_out",  out,             exp_w);
      chk("flush3_mask", 256'(outMask),   256'(8'h07));
      pop();
      push_lanes(32'h0, 10, 3);
      valid = 1'b1;
      data  = 32'hD;
      flush = 1'b1;
      cyc();
      valid = 1'b0;
      flush = 1'b0;
      exp_w[127:96] = 32'hD;
      chk("flush4_out",  out,           exp_w);
      chk("flush4_mask", 256'(outMask), 256'(8'h0F));
      pop();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      chk("flush_noop_empty", 256'(fifoEmpty), 256'(1));
      push_lanes(32'h30, 0, 7);
      valid = 1'b1;
      data  = 32'h37;
      flush = 1'b1;
      cyc();
      valid = 1'b0;
      flush = 1'b0;
      chk("flush_full_out",  out,           mk_word(32'h30));
      chk("flush_full_mask", 256'(outMask), 256'(8'hFF));
      pop();
      chk("flush_full_single_commit", 256'(fifoEmpty), 256'(1));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
